// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types: store opcodes, store FSM states, data-memory write payload.
package mips_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned BE_W  = XLEN / 8;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    OP_SB  = 2'b00,
    OP_SH  = 2'b01,
    OP_SW  = 2'b10,
    OP_RSV = 2'b11
  } st_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } store_state_e;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [BE_W-1:0] be;
  } dm_wr_t;

  // Word-align a byte address by clearing the byte offset.
  function automatic logic [XLEN-1:0] word_addr(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/store_lane_align.sv
// Combinational lane replication, byte-enable generation and alignment check for stores.
module store_lane_align
  import mips_pkg::*;
(
  input  logic [1:0]      op,
  input  logic [1:0]      byte_off,
  input  logic [XLEN-1:0] data,
  output logic [XLEN-1:0] wdata_c,
  output logic [BE_W-1:0] be_c,
  output logic            aligned_c,
  output logic            op_ok_c
);

  // Decode op into replicated write data, lane enables and an alignment flag.
  always_comb begin
    wdata_c   = data;
    be_c      = '0;
    aligned_c = 1'b0;
    op_ok_c   = 1'b1;
    case (st_op_e'(op))
      OP_SB: begin
        wdata_c   = {4{data[7:0]}};
        be_c      = 4'b0001 << byte_off;
        aligned_c = 1'b1;
      end
      OP_SH: begin
        wdata_c   = {2{data[15:0]}};
        be_c      = byte_off[1] ? 4'b1100 : 4'b0011;
        aligned_c = ~byte_off[0];
      end
      OP_SW: begin
        wdata_c   = data;
        be_c      = 4'b1111;
        aligned_c = (byte_off == 2'b00);
      end
      default: begin
        op_ok_c = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mem_store_unit.sv
// MEM-stage store unit: issues one registered data-memory write per store and
// holds it until acknowledged or until the wait limit expires.
module mem_store_unit
  import mips_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            st_valid,
  input  logic [1:0]      st_op,
  input  logic [XLEN-1:0] st_addr,
  input  logic [XLEN-1:0] st_data,
  input  logic            flush,
  input  logic            dm_ack,
  output logic            dm_req,
  output logic [XLEN-1:0] dm_addr,
  output logic [XLEN-1:0] dm_wdata,
  output logic [BE_W-1:0] dm_be,
  output logic            stall,
  output logic            done,
  output logic            misalign_exc,
  output logic            timeout_err
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_LIMIT - 1);

  store_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  dm_wr_t           wr_q, wr_d;
  logic             req_q, req_d;
  logic             done_q, done_d;
  logic             mis_q, mis_d;
  logic             tmo_q, tmo_d;

  logic [XLEN-1:0]  lane_wdata;
  logic [BE_W-1:0]  lane_be;
  logic             lane_aligned;
  logic             lane_op_ok;
  logic             store_seen;
  logic             accept;
  logic             misaligned;

  store_lane_align u_lane (
    .op        (st_op),
    .byte_off  (st_addr[1:0]),
    .data      (st_data),
    .wdata_c   (lane_wdata),
    .be_c      (lane_be),
    .aligned_c (lane_aligned),
    .op_ok_c   (lane_op_ok)
  );

  // Qualify the incoming store; only IDLE looks at it.
  assign store_seen = (state_q == ST_IDLE) && st_valid && !flush && lane_op_ok;
  assign accept     = store_seen && lane_aligned;
  assign misaligned = store_seen && !lane_aligned;

  // Freeze upstream while a store is being taken or is waiting on memory.
  assign stall = rst_n && (accept || ((state_q == ST_BUSY) && !dm_ack));

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    req_d   = req_q;
    done_d  = 1'b0;
    mis_d   = 1'b0;
    tmo_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          wr_d.addr  = word_addr(st_addr);
          wr_d.wdata = lane_wdata;
          wr_d.be    = lane_be;
          req_d      = 1'b1;
          cnt_d      = '0;
          state_d    = ST_BUSY;
        end else if (misaligned) begin
          mis_d = 1'b1;
        end
      end
      ST_BUSY: begin
        // Ack takes priority over the timeout on the limit cycle.
        if (dm_ack) begin
          req_d   = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          req_d   = 1'b0;
          tmo_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      wr_q    <= '0;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
      mis_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      req_q   <= req_d;
      done_q  <= done_d;
      mis_q   <= mis_d;
      tmo_q   <= tmo_d;
    end
  end

  assign dm_req       = req_q;
  assign dm_addr      = wr_q.addr;
  assign dm_wdata     = wr_q.wdata;
  assign dm_be        = wr_q.be;
  assign done         = done_q;
  assign misalign_exc = mis_q;
  assign timeout_err  = tmo_q;

endmodule

// File: tb/tb_mem_store_unit.sv
// Directed bench for mem_store_unit: a vector table for single stores plus
// hand sequences for wait, timeout, flush, reset and back-to-back behaviour.
module tb_mem_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st_valid;
  logic [1:0]  st_op;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        flush;
  logic        dm_ack;

  logic        req, stall, done, mis, tmo;
  logic [31:0] addr, wdata;
  logic [3:0]  be;

  logic        req4, stall4, done4, mis4, tmo4;
  logic [31:0] addr4, wdata4;
  logic [3:0]  be4;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_store_unit dut (
    .clk(clk), .rst_n(rst_n), .st_valid(st_valid), .st_op(st_op),
    .st_addr(st_addr), .st_data(st_data), .flush(flush), .dm_ack(dm_ack),
    .dm_req(req), .dm_addr(addr), .dm_wdata(wdata), .dm_be(be),
    .stall(stall), .done(done), .misalign_exc(mis), .timeout_err(tmo)
  );

  mem_store_unit #(.WAIT_LIMIT(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .st_valid(st_valid), .st_op(st_op),
    .st_addr(st_addr), .st_data(st_data), .flush(flush), .dm_ack(dm_ack),
    .dm_req(req4), .dm_addr(addr4), .dm_wdata(wdata4), .dm_be(be4),
    .stall(stall4), .done(done4), .misalign_exc(mis4), .timeout_err(tmo4)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] d;
    logic        fl;
    logic        exp_acc;
    logic        exp_mis;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_be;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    st_valid = 1'b0; st_op = 2'b00; st_addr = '0; st_data = '0;
    flush = 1'b0; dm_ack = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    @(posedge clk); @(posedge clk); #1;
    chk({tag, "_rst_req"},   {31'd0, req},  32'd0);
    chk({tag, "_rst_addr"},  addr,          32'd0);
    chk({tag, "_rst_wdata"}, wdata,         32'd0);
    chk({tag, "_rst_be"},    {28'd0, be},   32'd0);
    chk({tag, "_rst_flags"}, {29'd0, done, mis, tmo}, 32'd0);
    chk({tag, "_rst_req4"},  {31'd0, req4}, 32'd0);
    rst_n = 1'b1;
  endtask

  // Present one store in IDLE, ack it one cycle into BUSY when accepted.
  task automatic run_vec(input int i, input vec_t v);
    @(negedge clk);
    st_valid = 1'b1; st_op = v.op; st_addr = v.a; st_data = v.d; flush = v.fl;
    #1 chk($sformatf("v%0d_stall", i), {31'd0, stall}, {31'd0, v.exp_acc});
    @(posedge clk); #1;
    st_valid = 1'b0; flush = 1'b0;
    chk($sformatf("v%0d_req", i), {31'd0, req}, {31'd0, v.exp_acc});
    chk($sformatf("v%0d_mis", i), {31'd0, mis}, {31'd0, v.exp_mis});
    if (v.exp_acc) begin
      chk($sformatf("v%0d_addr", i),  addr,  {v.a[31:2], 2'b00});
      chk($sformatf("v%0d_wdata", i), wdata, v.exp_wdata);
      chk($sformatf("v%0d_be", i),    {28'd0, be}, {28'd0, v.exp_be});
      dm_ack = 1'b1;
      @(posedge clk); #1;
      dm_ack = 1'b0;
      chk($sformatf("v%0d_done", i),    {31'd0, done}, 32'd1);
      chk($sformatf("v%0d_reqdrop", i), {31'd0, req},  32'd0);
    end else begin
      @(posedge clk); #1;
      chk($sformatf("v%0d_mis_end", i), {31'd0, mis}, 32'd0);
      chk($sformatf("v%0d_noreq", i),   {31'd0, req}, 32'd0);
      chk($sformatf("v%0d_nodone", i),  {31'd0, done}, 32'd0);
    end
  endtask

  // Drive a sw and let it be accepted; returns one cycle into BUSY.
  task automatic accept_sw(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    st_valid = 1'b1; st_op = 2'b10; st_addr = a; st_data = d; flush = 1'b0;
    @(posedge clk); #1;
    st_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();

    //          op     addr          data          fl  acc  mis  wdata         be
    vecs[0]  = '{2'b00, 32'h0000_1003, 32'h1234_56AB, 0, 1, 0, 32'hABAB_ABAB, 4'b1000};
    vecs[1]  = '{2'b00, 32'h0000_2000, 32'h0000_0011, 0, 1, 0, 32'h1111_1111, 4'b0001};
    vecs[2]  = '{2'b00, 32'h0000_2001, 32'hFFFF_FF22, 0, 1, 0, 32'h2222_2222, 4'b0010};
    vecs[3]  = '{2'b01, 32'h0000_1002, 32'h0000_BEEF, 0, 1, 0, 32'hBEEF_BEEF, 4'b1100};
    vecs[4]  = '{2'b01, 32'h0000_1000, 32'hDEAD_CAFE, 0, 1, 0, 32'hCAFE_CAFE, 4'b0011};
    vecs[5]  = '{2'b01, 32'h0000_1001, 32'h0000_BEEF, 0, 0, 1, 32'h0,         4'b0000};
    vecs[6]  = '{2'b01, 32'h0000_1003, 32'h0000_BEEF, 0, 0, 1, 32'h0,         4'b0000};
    vecs[7]  = '{2'b10, 32'h0000_4000, 32'hCAFE_F00D, 0, 1, 0, 32'hCAFE_F00D, 4'b1111};
    vecs[8]  = '{2'b10, 32'h0000_4002, 32'hCAFE_F00D, 0, 0, 1, 32'h0,         4'b0000};
    vecs[9]  = '{2'b10, 32'h0000_4001, 32'hCAFE_F00D, 0, 0, 1, 32'h0,         4'b0000};
    vecs[10] = '{2'b11, 32'h0000_4000, 32'hCAFE_F00D, 0, 0, 0, 32'h0,         4'b0000};
    vecs[11] = '{2'b10, 32'h0000_4000, 32'hCAFE_F00D, 1, 0, 0, 32'h0,         4'b0000};

    do_reset("init");
    for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

    // dm_ack while idle is ignored.
    @(negedge clk); dm_ack = 1'b1;
    @(posedge clk); #1;
    chk("idle_ack_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1; dm_ack = 1'b0;
    chk("idle_ack_done", {31'd0, done}, 32'd0);
    chk("idle_ack_req",  {31'd0, req},  32'd0);

    // sw held for 6 cycles, ack on the sixth.
    do_reset("wait");
    accept_sw(32'h0000_8004, 32'h8765_4321);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("hold%0d_req", k),   {31'd0, req}, 32'd1);
      chk($sformatf("hold%0d_addr", k),  addr,  32'h0000_8004);
      chk($sformatf("hold%0d_wdata", k), wdata, 32'h8765_4321);
      chk($sformatf("hold%0d_be", k),    {28'd0, be}, 32'h0000_000F);
      chk($sformatf("hold%0d_stall", k), {31'd0, stall}, 32'd1);
      chk($sformatf("hold%0d_done", k),  {31'd0, done}, 32'd0);
      @(posedge clk); #1;
    end
    chk("hold5_req",  {31'd0, req}, 32'd1);
    chk("hold5_addr", addr, 32'h0000_8004);
    dm_ack = 1'b1;
    #1 chk("hold5_stall_ack", {31'd0, stall}, 32'd0);
    @(posedge clk); #1; dm_ack = 1'b0;
    chk("hold_done",    {31'd0, done}, 32'd1);
    chk("hold_reqdrop", {31'd0, req},  32'd0);
    @(posedge clk); #1;
    chk("hold_done_once", {31'd0, done}, 32'd0);

    // Timeout on the WAIT_LIMIT=4 instance.
    do_reset("tmo");
    accept_sw(32'h0000_9000, 32'h0000_0001);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("tmo_busy%0d_req", k), {31'd0, req4}, 32'd1);
      chk($sformatf("tmo_busy%0d_tmo", k), {31'd0, tmo4}, 32'd0);
      @(posedge clk); #1;
    end
    chk("tmo_pulse",   {31'd0, tmo4},  32'd1);
    chk("tmo_reqdrop", {31'd0, req4},  32'd0);
    chk("tmo_nodone",  {31'd0, done4}, 32'd0);
    @(posedge clk); #1;
    chk("tmo_pulse_end", {31'd0, tmo4}, 32'd0);

    // Ack on the limit cycle wins over timeout.
    do_reset("race");
    accept_sw(32'h0000_9000, 32'h0000_0002);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
    end
    chk("race_req_before", {31'd0, req4}, 32'd1);
    dm_ack = 1'b1;
    @(posedge clk); #1; dm_ack = 1'b0;
    chk("race_done", {31'd0, done4}, 32'd1);
    chk("race_tmo",  {31'd0, tmo4},  32'd0);
    chk("race_req",  {31'd0, req4},  32'd0);

    // Flush during BUSY does not abort the write.
    do_reset("flush");
    accept_sw(32'h0000_A000, 32'h0BAD_F00D);
    flush = 1'b1;
    @(posedge clk); #1;
    chk("flush_busy_req", {31'd0, req}, 32'd1);
    dm_ack = 1'b1;
    @(posedge clk); #1; dm_ack = 1'b0; flush = 1'b0;
    chk("flush_done", {31'd0, done}, 32'd1);

    // Back-to-back: new store taken in the done cycle.
    do_reset("b2b");
    accept_sw(32'h0000_0010, 32'h0000_005A);
    dm_ack = 1'b1;
    @(posedge clk); #1; dm_ack = 1'b0;
    st_valid = 1'b1; st_op = 2'b10; st_addr = 32'h0000_0020; st_data = 32'h1122_3344;
    #1;
    chk("b2b_done",  {31'd0, done},  32'd1);
    chk("b2b_stall", {31'd0, stall}, 32'd1);
    @(posedge clk); #1; st_valid = 1'b0;
    chk("b2b_req",   {31'd0, req}, 32'd1);
    chk("b2b_addr",  addr,  32'h0000_0020);
    chk("b2b_wdata", wdata, 32'h1122_3344);

    // Reset mid-BUSY abandons the write.
    accept_sw(32'h0000_0030, 32'h5555_AAAA);
    @(negedge clk);
    rst_n = 1'b0; st_valid = 1'b1; st_op = 2'b10; st_addr = 32'h0000_0040;
    #1 chk("rst_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    chk("rstb_req",   {31'd0, req}, 32'd0);
    chk("rstb_addr",  addr,  32'd0);
    chk("rstb_wdata", wdata, 32'd0);
    chk("rstb_be",    {28'd0, be}, 32'd0);
    chk("rstb_flags", {29'd0, done, mis, tmo}, 32'd0);
    rst_n = 1'b1; st_valid = 1'b0;
    @(posedge clk); #1;
    chk("rstb_nodone", {31'd0, done}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
